// File: rtl/regfile_psr_pkg.sv
// Shared constants for the operand-fetch / writeback stage: opcodes, PSR flag
// positions, branch condition codes and the per-opcode PSR load mask.
package regfile_psr_pkg;

    localparam int OPW = 5;   // opcode width
    localparam int FW  = 5;   // flag / PSR width
    localparam int CCW = 4;   // condition code width
    localparam int IMW = 8;   // immediate width

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_CMP  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_NOT  = 5'd6,
        OP_LSH  = 5'd7,
        OP_RSH  = 5'd8,
        OP_ARSH = 5'd9
    } op_e;

    // PSR / alu_flags bit positions
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [CCW-1:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
        CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
        CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
    } cc_e;

    // Which PSR bits an opcode is allowed to load; everything else holds.
    function automatic logic [FW-1:0] psr_mask(input logic [OPW-1:0] op);
        logic [FW-1:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                m[FLAG_C] = 1'b1;
                m[FLAG_F] = 1'b1;
            end
            OP_CMP: begin
                m[FLAG_L] = 1'b1;
                m[FLAG_Z] = 1'b1;
                m[FLAG_N] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // CMP and undefined opcodes produce no register result.
    function automatic logic wb_en(input logic [OPW-1:0] op);
        return !(op == OP_CMP || op > OP_ARSH);
    endfunction

endpackage

// File: rtl/regfile_psr_if.sv
// Controller <-> regfile/ALU bundle. The master side issues ops, returns the
// ALU result and picks the branch condition; the slave side is regfile_psr.
interface regfile_psr_if
    import regfile_psr_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 16
);
    localparam int IW = $clog2(NREG);

    logic            op_valid;
    logic [OPW-1:0]  op_code;
    logic [IW-1:0]   src_idx;
    logic [IW-1:0]   dst_idx;
    logic            imm_sel;
    logic [IMW-1:0]  imm;
    logic            imm_signed;

    logic [DW-1:0]   alu_rsrc;
    logic [DW-1:0]   alu_rdest;
    logic [OPW-1:0]  alu_op;
    logic            alu_valid;
    logic [DW-1:0]   alu_out;
    logic [FW-1:0]   alu_flags;

    logic [CCW-1:0]  cond_code;
    logic            cond_true;
    logic [FW-1:0]   psr;

    modport master (
        output op_valid, op_code, src_idx, dst_idx, imm_sel, imm, imm_signed,
        output alu_out, alu_flags, cond_code,
        input  alu_rsrc, alu_rdest, alu_op, alu_valid, cond_true, psr
    );

    modport slave (
        input  op_valid, op_code, src_idx, dst_idx, imm_sel, imm, imm_signed,
        input  alu_out, alu_flags, cond_code,
        output alu_rsrc, alu_rdest, alu_op, alu_valid, cond_true, psr
    );

endinterface

// File: rtl/regfile_psr_cond_eval.sv
// Branch condition evaluation against the committed PSR. Purely combinational.
module regfile_psr_cond_eval
    import regfile_psr_pkg::*;
(
    input  logic [FW-1:0]  psr_i,
    input  logic [CCW-1:0] cond_code_i,
    output logic           cond_true_o
);
    logic c, l, f, z, n;

    assign c = psr_i[FLAG_C];
    assign l = psr_i[FLAG_L];
    assign f = psr_i[FLAG_F];
    assign z = psr_i[FLAG_Z];
    assign n = psr_i[FLAG_N];

    // Condition table decode
    always_comb begin
        cond_true_o = 1'b0;
        case (cond_code_i)
            CC_EQ:   cond_true_o = z;
            CC_NE:   cond_true_o = !z;
            CC_CS:   cond_true_o = c;
            CC_CC:   cond_true_o = !c;
            CC_HI:   cond_true_o = l;
            CC_LS:   cond_true_o = !l;
            CC_GT:   cond_true_o = n;
            CC_LE:   cond_true_o = !n;
            CC_FS:   cond_true_o = f;
            CC_FC:   cond_true_o = !f;
            CC_LO:   cond_true_o = !l && !z;
            CC_HS:   cond_true_o = l || z;
            CC_LT:   cond_true_o = !n && !z;
            CC_GE:   cond_true_o = n || z;
            CC_UC:   cond_true_o = 1'b1;
            default: cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_psr.sv
// Operand-fetch (F) / writeback (W) stage around the ALU: register array,
// writeback forwarding, immediate extension, F/W pipeline registers and PSR.
module regfile_psr
    import regfile_psr_pkg::*;
#(
    parameter int NREG = 16,
    parameter int DW   = 16
)(
    input logic          clk,
    input logic          rst_n,
    regfile_psr_if.slave bus
);
    localparam int IW = $clog2(NREG);

    logic [DW-1:0]  regs_q [NREG];

    logic [DW-1:0]  alu_rsrc_q,  alu_rsrc_d;
    logic [DW-1:0]  alu_rdest_q, alu_rdest_d;
    logic [OPW-1:0] alu_op_q,    alu_op_d;
    logic           alu_valid_q, alu_valid_d;
    logic [IW-1:0]  dst_q,       dst_d;
    logic           wb_q,        wb_d;
    logic [FW-1:0]  psr_q,       psr_d;

    logic [DW-1:0]  ext_imm;
    logic [DW-1:0]  src_val;
    logic [DW-1:0]  dst_val;
    logic           commit;
    logic [FW-1:0]  upd_mask;

    // An op in W writes back at the closing edge of this cycle.
    assign commit = alu_valid_q && wb_q;

    assign ext_imm = bus.imm_signed ? {{(DW-IMW){bus.imm[IMW-1]}}, bus.imm}
                                    : {{(DW-IMW){1'b0}}, bus.imm};

    // Register read with bypass of the result being committed this cycle
    always_comb begin
        src_val = regs_q[bus.src_idx];
        dst_val = regs_q[bus.dst_idx];
        if (commit && (dst_q == bus.src_idx)) src_val = bus.alu_out;
        if (commit && (dst_q == bus.dst_idx)) dst_val = bus.alu_out;
    end

    // F stage next-state: operands hold while idle, only alu_valid drops
    always_comb begin
        alu_rsrc_d  = alu_rsrc_q;
        alu_rdest_d = alu_rdest_q;
        alu_op_d    = alu_op_q;
        dst_d       = dst_q;
        wb_d        = wb_q;
        alu_valid_d = bus.op_valid;
        if (bus.op_valid) begin
            alu_rsrc_d  = bus.imm_sel ? ext_imm : src_val;
            alu_rdest_d = dst_val;
            alu_op_d    = bus.op_code;
            dst_d       = bus.dst_idx;
            wb_d        = wb_en(bus.op_code);
        end
    end

    // F stage pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rsrc_q  <= '0;
            alu_rdest_q <= '0;
            alu_op_q    <= '0;
            alu_valid_q <= 1'b0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
        end else begin
            alu_rsrc_q  <= alu_rsrc_d;
            alu_rdest_q <= alu_rdest_d;
            alu_op_q    <= alu_op_d;
            alu_valid_q <= alu_valid_d;
            dst_q       <= dst_d;
            wb_q        <= wb_d;
        end
    end

    // W stage register writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[dst_q] <= bus.alu_out;
        end
    end

    // Only the opcode's masked flag bits load, so undriven flags never leak in
    assign upd_mask = alu_valid_q ? psr_mask(alu_op_q) : '0;
    assign psr_d    = (psr_q & ~upd_mask) | (bus.alu_flags & upd_mask);

    // W stage PSR commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) psr_q <= '0;
        else        psr_q <= psr_d;
    end

    regfile_psr_cond_eval u_cond_eval (
        .psr_i       (psr_q),
        .cond_code_i (bus.cond_code),
        .cond_true_o (bus.cond_true)
    );

    assign bus.alu_rsrc  = alu_rsrc_q;
    assign bus.alu_rdest = alu_rdest_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_valid = alu_valid_q;
    assign bus.psr       = psr_q;

endmodule

// File: tb/tb_regfile_psr.sv
// Bench for regfile_psr: acts as controller and ALU. An architectural model of
// the registers/PSR predicts each op's operands, which are queued at issue and
// compared when the op appears on alu_* one cycle later.
module tb_regfile_psr;
    import regfile_psr_pkg::*;

    typedef struct packed {
        logic [15:0] rsrc;
        logic [15:0] rdest;
        logic [4:0]  op;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_valid;
    sb_t  sbq[$];
    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;

    regfile_psr_if bus ();

    regfile_psr u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU; flag bits the op does not define are driven 1 on purpose
    function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] rs,
                                           input logic [15:0] rd);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  f;
        r = 16'hDEAD;
        f = 5'b11111;
        s = '0;
        case (op)
            5'd0: begin
                s = {1'b0, rd} + {1'b0, rs}; r = s[15:0];
                f[0] = s[16]; f[2] = (rd[15] == rs[15]) && (r[15] != rd[15]);
            end
            5'd1: begin
                s = {1'b0, rd} - {1'b0, rs}; r = s[15:0];
                f[0] = s[16]; f[2] = (rd[15] != rs[15]) && (r[15] != rd[15]);
            end
            5'd2: begin
                r = rd;
                f[1] = rs > rd; f[3] = rs == rd; f[4] = $signed(rs) > $signed(rd);
            end
            5'd3: r = rd & rs;
            5'd4: r = rd | rs;
            5'd5: r = rd ^ rs;
            5'd6: r = ~rs;
            5'd7: r = rd << rs[3:0];
            5'd8: r = rd >> rs[3:0];
            5'd9: r = 16'($signed(rd) >>> rs[3:0]);
            default: ;
        endcase
        return {f, r};
    endfunction

    function automatic logic [4:0] exp_mask(input logic [4:0] op);
        if (op == 5'd0 || op == 5'd1) return 5'b00101;
        if (op == 5'd2)               return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic logic exp_cond(input logic [3:0] cc, input logic [4:0] p);
        logic c, l, f, z, n;
        {n, z, f, l, c} = p;
        case (cc)
            4'h0: return z;        4'h1: return !z;
            4'h2: return c;        4'h3: return !c;
            4'h4: return l;        4'h5: return !l;
            4'h6: return n;        4'h7: return !n;
            4'h8: return f;        4'h9: return !f;
            4'hA: return !l && !z; 4'hB: return l || z;
            4'hC: return !n && !z; 4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        {bus.alu_flags, bus.alu_out} = alu_fn(bus.alu_op, bus.alu_rsrc, bus.alu_rdest);
    end

    // Scoreboard drain: every live alu_* cycle must match the oldest issued op
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && bus.alu_valid) begin
            n_valid++;
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("alu_rsrc",  32'(bus.alu_rsrc),  32'(e.rsrc));
                chk("alu_rdest", 32'(bus.alu_rdest), 32'(e.rdest));
                chk("alu_op",    32'(bus.alu_op),    32'(e.op));
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [3:0] s, input logic [3:0] d,
                         input logic isel, input logic [7:0] im, input logic isg);
        logic [15:0] rs, rd;
        logic [20:0] res;
        sb_t e;
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.op_code    = op;
        bus.src_idx    = s;
        bus.dst_idx    = d;
        bus.imm_sel    = isel;
        bus.imm        = im;
        bus.imm_signed = isg;
        rs = isel ? (isg ? {{8{im[7]}}, im} : {8'h00, im}) : m_reg[s];
        rd = m_reg[d];
        e.rsrc = rs; e.rdest = rd; e.op = op;
        sbq.push_back(e);
        res = alu_fn(op, rs, rd);
        if (op != 5'd2 && op <= 5'd9) m_reg[d] = res[15:0];
        m_psr = (m_psr & ~exp_mask(op)) | (res[20:16] & exp_mask(op));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.op_valid = 1'b0;
        end
    endtask

    // Undefined opcode with imm 0: reads reg[i] onto alu_rdest without side effects
    task automatic probe_all();
        for (int i = 0; i < 16; i++) issue(5'd12, 4'd0, 4'(i), 1'b1, 8'h00, 1'b0);
        idle(2);
    endtask

    task automatic set_reg(input logic [3:0] r, input logic [7:0] v);
        issue(5'd5, r, r, 1'b0, 8'h00, 1'b0);
        issue(5'd0, 4'd0, r, 1'b1, v, 1'b1);
    endtask

    task automatic check_conds(input string tag);
        for (int cc = 0; cc < 16; cc++) begin
            bus.cond_code = 4'(cc);
            #1;
            chk(tag, 32'(bus.cond_true), 32'(exp_cond(4'(cc), m_psr)));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_psr = '0;
        sbq.delete();
    endtask

    initial begin
        int v0;
        n_vec = 0; n_err = 0; n_valid = 0;
        model_reset();
        rst_n = 1'b0;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.src_idx = '0; bus.dst_idx = '0;
        bus.imm_sel = 1'b0; bus.imm = '0; bus.imm_signed = 1'b0; bus.cond_code = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsrc",  32'(bus.alu_rsrc),  32'd0);
        chk("rst_rdest", 32'(bus.alu_rdest), 32'd0);
        chk("rst_valid", 32'(bus.alu_valid), 32'd0);
        chk("rst_psr",   32'(bus.psr),       32'd0);
        rst_n = 1'b1;
        probe_all();

        // ADD immediate chain, second op reads r1 through the bypass
        issue(5'd0, 4'd0, 4'd1, 1'b1, 8'h05, 1'b1);
        issue(5'd0, 4'd0, 4'd1, 1'b1, 8'hFF, 1'b1);
        idle(2);
        chk("chain_psr_c", 32'(bus.psr[FLAG_C]), 32'd1);
        chk("chain_psr", 32'(bus.psr), 32'(m_psr));

        // Zero-extended immediate
        issue(5'd0, 4'd0, 4'd2, 1'b1, 8'h80, 1'b0);
        idle(2);

        // CMP equal, then full condition table against committed PSR
        set_reg(4'd3, 8'd5);
        set_reg(4'd4, 8'd5);
        issue(5'd2, 4'd4, 4'd3, 1'b0, 8'h00, 1'b0);
        idle(2);
        chk("cmp_eq_psr", 32'(bus.psr), 32'(m_psr));
        check_conds("cond_eq");

        // PSR masking: C set by ADD survives AND, then CMP less-than
        set_reg(4'd5, 8'hFF);
        issue(5'd0, 4'd0, 4'd5, 1'b1, 8'h01, 1'b0);
        idle(2);
        chk("carry_set", 32'(bus.psr[FLAG_C]), 32'd1);
        issue(5'd3, 4'd5, 4'd6, 1'b0, 8'h00, 1'b0);
        idle(2);
        chk("and_psr_hold", 32'(bus.psr), 32'(m_psr));
        set_reg(4'd3, 8'd2);
        set_reg(4'd4, 8'd7);
        issue(5'd2, 4'd4, 4'd3, 1'b0, 8'h00, 1'b0);
        idle(2);
        chk("cmp_lt_psr", 32'(bus.psr), 32'(m_psr));
        check_conds("cond_lt");

        // Single op followed by idle cycles: exactly one alu_valid pulse
        v0 = n_valid;
        issue(5'd0, 4'd0, 4'd7, 1'b1, 8'h03, 1'b0);
        idle(3);
        chk("valid_pulses", 32'(n_valid - v0), 32'd1);
        probe_all();

        // Random back-to-back traffic exercising both bypass paths
        for (int k = 0; k < 60; k++) begin
            issue(5'($urandom_range(0, 13)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        chk("rand_psr", 32'(bus.psr), 32'(m_psr));
        probe_all();

        // Reset while an op is in W: op discarded, everything returns to zero
        set_reg(4'd8, 8'h44);
        issue(5'd0, 4'd0, 4'd6, 1'b1, 8'h11, 1'b0);
        @(posedge clk);
        #1;
        chk("midop_valid", 32'(bus.alu_valid), 32'd1);
        rst_n = 1'b0;
        bus.op_valid = 1'b0;
        model_reset();
        #1;
        chk("midrst_rsrc",  32'(bus.alu_rsrc),  32'd0);
        chk("midrst_rdest", 32'(bus.alu_rdest), 32'd0);
        chk("midrst_op",    32'(bus.alu_op),    32'd0);
        chk("midrst_valid", 32'(bus.alu_valid), 32'd0);
        chk("midrst_psr",   32'(bus.psr),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        probe_all();
        chk("post_rst_psr", 32'(bus.psr), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
